// File: rtl/axis_packet_arbiter.sv
// Two-source AXI-Stream packet arbiter. Grants whole packets (terminated by
// last or by a forced last after MAX_BEATS beats) to one source at a time,
// with fixed or round-robin priority. The granted source is passed through
// combinationally, so there is no buffering and no added per-beat latency.
module axis_packet_arbiter #(
  parameter int DATA_WIDTH = 24,
  parameter int MAX_BEATS  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s0_axis_data,
  input  logic                  s0_axis_valid,
  input  logic                  s0_axis_last,
  output logic                  s0_axis_ready,
  input  logic [DATA_WIDTH-1:0] s1_axis_data,
  input  logic                  s1_axis_valid,
  input  logic                  s1_axis_last,
  output logic                  s1_axis_ready,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  input  logic                  fixed_prio,
  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1,
  input  logic                  err_clr,
  output logic                  err_overlen
);

  // Beat counter only needs to reach MAX_BEATS-1; keep at least one bit.
  localparam int BCW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BCW-1:0] LAST_IDX = BCW'(MAX_BEATS - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;  // 0: s0 served last, 1: s1
  logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt1_q;
  logic                 err_q;

  logic                  sel_valid, sel_last, out_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  done0, done1, forced;

  assign grant       = grant_q;
  assign pkt_cnt0    = pkt_cnt0_q;
  assign pkt_cnt1    = pkt_cnt1_q;
  assign err_overlen = err_q;

  // Arbitration, pass-through muxing and packet completion decode.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    done0         = 1'b0;
    done1         = 1'b0;
    forced        = 1'b0;
    out_last      = 1'b0;
    m_axis_valid  = 1'b0;
    m_axis_last   = 1'b0;
    m_axis_data   = '0;
    s0_axis_ready = 1'b0;
    s1_axis_ready = 1'b0;
    sel_valid     = grant_q[1] ? s1_axis_valid : s0_axis_valid;
    sel_last      = grant_q[1] ? s1_axis_last  : s0_axis_last;
    sel_data      = grant_q[1] ? s1_axis_data  : s0_axis_data;
    case (state_q)
      IDLE: begin
        if (s0_axis_valid || s1_axis_valid) begin
          state_d    = BUSY;
          beat_cnt_d = '0;
          if (s0_axis_valid && s1_axis_valid)
            grant_d = (fixed_prio || last_grant_q) ? 2'b01 : 2'b10;
          else
            grant_d = s0_axis_valid ? 2'b01 : 2'b10;
        end
      end
      BUSY: begin
        out_last      = sel_last || (beat_cnt_q == LAST_IDX);
        m_axis_valid  = sel_valid;
        m_axis_last   = out_last;
        m_axis_data   = sel_data;
        s0_axis_ready = grant_q[0] & m_axis_ready;
        s1_axis_ready = grant_q[1] & m_axis_ready;
        if (sel_valid && m_axis_ready) begin
          if (out_last) begin
            beat_cnt_d   = '0;
            last_grant_d = grant_q[1];
            done0        = grant_q[0];
            done1        = grant_q[1];
            forced       = ~sel_last;
            grant_d      = 2'b00;
            state_d      = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, grant and beat position registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Per-source completed-packet counters (free-running wrap).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      if (done0) pkt_cnt0_q <= pkt_cnt0_q + CNT_WIDTH'(1);
      if (done1) pkt_cnt1_q <= pkt_cnt1_q + CNT_WIDTH'(1);
    end
  end

  // Sticky over-length flag; a new forced last beats a simultaneous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      err_q <= 1'b0;
    else if (forced)  err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
module tb_axis_packet_arbiter;
  localparam int DW = 24;
  localparam int MB = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] s0_axis_data, s1_axis_data, m_axis_data;
  logic          s0_axis_valid, s0_axis_last, s0_axis_ready;
  logic          s1_axis_valid, s1_axis_last, s1_axis_ready;
  logic          m_axis_valid, m_axis_last, m_axis_ready;
  logic          fixed_prio, err_clr, err_overlen;
  logic [1:0]    grant;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  always #5 clk = ~clk;

  axis_packet_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn),
    .s0_axis_data(s0_axis_data), .s0_axis_valid(s0_axis_valid),
    .s0_axis_last(s0_axis_last), .s0_axis_ready(s0_axis_ready),
    .s1_axis_data(s1_axis_data), .s1_axis_valid(s1_axis_valid),
    .s1_axis_last(s1_axis_last), .s1_axis_ready(s1_axis_ready),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
    .fixed_prio(fixed_prio), .grant(grant),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
    .err_clr(err_clr), .err_overlen(err_overlen)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  // Source beat queues: the head of each queue is what that source offers.
  beat_t q0[$];
  beat_t q1[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the sink, who was served last, beats taken.
  int            owner = -1;
  int            prev  = 1;
  int            beats = 0;
  logic [CW-1:0] cnt0 = '0, cnt1 = '0;
  logic          err_m = 1'b0;
  int            s1_wins_while_s0 = 0;

  // Expected combinational outputs for the current cycle.
  logic [1:0]    e_grant;
  logic          e_valid, e_last, e_r0, e_r1, e_srclast;
  logic [DW-1:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int src, input int n, input logic term, input logic [DW-1:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = base + DW'(i);
      b.l = term && (i == n - 1);
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  task automatic drive();
    s0_axis_valid = (q0.size() != 0);
    s0_axis_data  = (q0.size() != 0) ? q0[0].d : '0;
    s0_axis_last  = (q0.size() != 0) ? q0[0].l : 1'b0;
    s1_axis_valid = (q1.size() != 0);
    s1_axis_data  = (q1.size() != 0) ? q1[0].d : '0;
    s1_axis_last  = (q1.size() != 0) ? q1[0].l : 1'b0;
  endtask

  task automatic model_reset();
    owner = -1; prev = 1; beats = 0;
    cnt0 = '0; cnt1 = '0; err_m = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_mvalid"}, 32'(m_axis_valid), 0);
    chk({tag, "_mlast"}, 32'(m_axis_last), 0);
    chk({tag, "_mdata"}, 32'(m_axis_data), 0);
    chk({tag, "_r0"}, 32'(s0_axis_ready), 0);
    chk({tag, "_r1"}, 32'(s1_axis_ready), 0);
    chk({tag, "_cnt0"}, 32'(pkt_cnt0), 0);
    chk({tag, "_cnt1"}, 32'(pkt_cnt1), 0);
    chk({tag, "_err"}, 32'(err_overlen), 0);
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic tick();
    logic set_err;
    drive();
    #1;
    e_grant = 2'b00; e_valid = 1'b0; e_last = 1'b0; e_data = '0;
    e_r0 = 1'b0; e_r1 = 1'b0; e_srclast = 1'b0;
    if (owner >= 0) begin
      e_grant   = (owner == 0) ? 2'b01 : 2'b10;
      e_valid   = (owner == 0) ? s0_axis_valid : s1_axis_valid;
      e_data    = (owner == 0) ? s0_axis_data  : s1_axis_data;
      e_srclast = (owner == 0) ? s0_axis_last  : s1_axis_last;
      e_last    = e_srclast || (beats == MB - 1);
      e_r0      = (owner == 0) && m_axis_ready;
      e_r1      = (owner == 1) && m_axis_ready;
    end
    chk("grant", 32'(grant), 32'(e_grant));
    chk("m_valid", 32'(m_axis_valid), 32'(e_valid));
    chk("m_data", 32'(m_axis_data), 32'(e_data));
    chk("m_last", 32'(m_axis_last), 32'(e_last));
    chk("s0_ready", 32'(s0_axis_ready), 32'(e_r0));
    chk("s1_ready", 32'(s1_axis_ready), 32'(e_r1));
    chk("pkt_cnt0", 32'(pkt_cnt0), 32'(cnt0));
    chk("pkt_cnt1", 32'(pkt_cnt1), 32'(cnt1));
    chk("err_overlen", 32'(err_overlen), 32'(err_m));
    if (owner == 1 && s0_axis_valid && fixed_prio && beats == 0) s1_wins_while_s0++;
    @(posedge clk);
    set_err = 1'b0;
    if (owner < 0) begin
      if (s0_axis_valid || s1_axis_valid) begin
        if (s0_axis_valid && s1_axis_valid) owner = fixed_prio ? 0 : 1 - prev;
        else                                owner = s0_axis_valid ? 0 : 1;
        beats = 0;
      end
    end else if (e_valid && m_axis_ready) begin
      if (owner == 0) void'(q0.pop_front());
      else            void'(q1.pop_front());
      if (e_last) begin
        if (owner == 0) cnt0 = cnt0 + 1'b1;
        else            cnt1 = cnt1 + 1'b1;
        set_err = !e_srclast;
        prev  = owner;
        owner = -1;
        beats = 0;
      end else begin
        beats++;
      end
    end
    if (set_err)      err_m = 1'b1;
    else if (err_clr) err_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || owner >= 0) && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_drain_timeout"}, 32'(n >= 300), 0);
    tick();
  endtask

  initial begin
    resetn = 1'b0; m_axis_ready = 1'b0; fixed_prio = 1'b0; err_clr = 1'b0;
    drive();
    repeat (2) @(negedge clk);
    // Reset state.
    m_axis_ready = 1'b1;
    #1 check_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);
    tick(); tick();

    // Single 2-beat packet from s0.
    push_pkt(0, 1, 1'b0, 24'h000111);
    push_pkt(0, 1, 1'b1, 24'h000222);
    repeat (5) tick();
    chk("single_pkt_cnt0", 32'(pkt_cnt0), 1);

    // Both sources busy, round-robin.
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 2, 1'b1, 24'h100000 + DW'(i * 16));
      push_pkt(1, 2, 1'b1, 24'h200000 + DW'(i * 16));
    end
    drain("rr");
    chk("rr_cnt0", 32'(pkt_cnt0), 5);
    chk("rr_cnt1", 32'(pkt_cnt1), 4);

    // Both sources busy, fixed priority.
    fixed_prio = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_pkt(0, 2, 1'b1, 24'h300000 + DW'(i * 16));
      push_pkt(1, 2, 1'b1, 24'h400000 + DW'(i * 16));
    end
    drain("fixed");
    chk("fixed_s1_never_wins", 32'(s1_wins_while_s0), 0);
    fixed_prio = 1'b0;

    // Sink back-pressure toggling mid-packet.
    push_pkt(0, 2, 1'b1, 24'h500000);
    for (int i = 0; i < 8; i++) begin
      m_axis_ready = i[0];
      tick();
    end
    m_axis_ready = 1'b1;
    drain("bp");

    // Over-length packet from s1, then a terminating beat.
    push_pkt(1, 3, 1'b0, 24'h600000);
    push_pkt(1, 1, 1'b1, 24'h600003);
    drain("ovl");
    chk("ovl_err", 32'(err_overlen), 1);
    chk("ovl_cnt1", 32'(pkt_cnt1), 32'(cnt1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    chk("ovl_err_cleared", 32'(err_overlen), 0);

    // Reset between L and R beats.
    push_pkt(0, 2, 1'b1, 24'h700000);
    tick();
    tick();
    resetn = 1'b0;
    #1 check_all_zero("midrst");
    q0.delete(); q1.delete();
    model_reset();
    drive();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    push_pkt(1, 2, 1'b1, 24'h800000);
    drain("postrst");
    chk("postrst_cnt1", 32'(pkt_cnt1), 1);

    // Randomized traffic, back-pressure, priority mode and error clears.
    for (int i = 0; i < 600; i++) begin
      m_axis_ready = ($urandom_range(0, 3) != 0);
      fixed_prio   = ($urandom_range(0, 3) == 0);
      err_clr      = ($urandom_range(0, 7) == 0);
      if (q0.size() < 6 && $urandom_range(0, 3) == 0)
        push_pkt(0, int'($urandom_range(1, 3)), 1'b1, DW'($urandom));
      if (q1.size() < 6 && $urandom_range(0, 3) == 0)
        push_pkt(1, int'($urandom_range(1, 3)), 1'b1, DW'($urandom));
      tick();
    end
    m_axis_ready = 1'b1;
    err_clr = 1'b0;
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Shares one AXI-Stream stereo packet sink between two AXI-Stream packet sources, typically the I2S transmit path.
- Source 0 is the ANC anti-noise stream; source 1 is the test-tone/passthrough stream.
- A packet is a run of beats terminated by last, nominally 2 beats (L, then R with last=1).
- Grants are packet-granular, so L/R pairs are never interleaved. Priority is fixed or round-robin; per-source packet counters and an over-length error flag are provided.

Parameters:
DATA_WIDTH, 24, sample width per beat
MAX_BEATS, 2, maximum beats per packet before a forced last (>=1)
CNT_WIDTH, 16, width of per-source packet counters

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
s0_axis_data  in  DATA_WIDTH  source 0 beat data
s0_axis_valid  in  1  source 0 valid
s0_axis_last  in  1  source 0 end of packet
s0_axis_ready  out  1  source 0 ready
s1_axis_data  in  DATA_WIDTH  source 1 beat data
s1_axis_valid  in  1  source 1 valid
s1_axis_last  in  1  source 1 end of packet
s1_axis_ready  out  1  source 1 ready
m_axis_data  out  DATA_WIDTH  granted beat data
m_axis_valid  out  1  granted valid
m_axis_last  out  1  end of packet (source last or forced)
m_axis_ready  in  1  sink ready
fixed_prio  in  1  1: source 0 always wins; 0: round-robin
grant  out  2  one-hot current grant (bit0 = s0, bit1 = s1), 00 when idle
pkt_cnt0  out  CNT_WIDTH  packets completed from source 0
pkt_cnt1  out  CNT_WIDTH  packets completed from source 1
err_clr  in  1  synchronous clear of err_overlen
err_overlen  out  1  sticky: a packet hit MAX_BEATS without last

Behaviour:
- Reset (resetn=0, async):
  - State returns to IDLE, grant=00, last_grant=1 (so s0 wins the first round-robin tie).
  - beat_cnt=0, pkt_cnt0=pkt_cnt1=0, err_overlen=0.
  - m_axis_valid=0, m_axis_last=0, m_axis_data=0, s0/s1_axis_ready=0, all immediately.
- Reset mid-packet abandons the packet. No completion is counted.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - All ready outputs are 0; m_axis_valid=0.
  - If any sN_axis_valid=1, register the winner into grant and go to BUSY next cycle.
  - Winner when only one is valid: that source.
  - Winner when both are valid and fixed_prio=1: s0.
  - Winner when both are valid and fixed_prio=0: the source not equal to last_grant.
  - fixed_prio is sampled only in IDLE.
- BUSY (grant = g):
  - m_axis_valid = sg_axis_valid; m_axis_data = sg_axis_data.
  - m_axis_last = sg_axis_last OR (beat_cnt == MAX_BEATS-1).
  - sg_axis_ready = m_axis_ready; the non-granted ready = 0.
  - This is a combinational path from the registered grant. There is no buffering and no added latency per beat.
  - Beat accepted = m_axis_valid & m_axis_ready. On an accepted non-last beat, beat_cnt increments.
  - On an accepted beat with m_axis_last=1:
    - beat_cnt returns to 0, last_grant becomes g, pkt_cntg increments (wraps at 2^CNT_WIDTH), state returns to IDLE.
    - If the last was forced (sg_axis_last=0), set err_overlen.
    - The source's remaining beats are arbitrated later as a new packet.
- Latency:
  - First beat is presented 1 cycle after valid is seen in IDLE.
  - There is exactly 1 idle bubble cycle between consecutive packets.
- Grant never changes while in BUSY, regardless of the other source's valid or a fixed_prio change.
- err_overlen: err_clr=1 clears it. If set and clear happen in the same cycle, set wins.
- MAX_BEATS=1: every beat is a forced-last packet unless its last is already 1.
- Sources must obey AXIS rules (valid held until accepted). The arbiter does not check this.

Test Plan:
- Only s0 sends 2-beat packets (0x000111, then 0x000222 with last), m_axis_ready=1:
  - grant=01 from cycle 1; m_axis sees both beats in consecutive cycles, last on beat 2.
  - pkt_cnt0=1, then IDLE with 1 bubble.
- Both valid continuously, fixed_prio=0, 4 packets each:
  - grant sequence 01,10,01,10,...; final pkt_cnt0=4, pkt_cnt1=4; no interleaving within a packet.
- Both valid, fixed_prio=1:
  - s1 is never granted while s0 is valid; s1_axis_ready stays 0.
- m_axis_ready toggles 1010 mid-packet:
  - data and last are held stable; sg_axis_ready mirrors m_axis_ready; beat_cnt advances only on accepted beats.
- s1 sends 3 beats without last, MAX_BEATS=2:
  - beat 2 is output with forced last; err_overlen=1; pkt_cnt1=1.
  - beat 3 forms a new packet after arbitration.
  - err_clr pulse clears the flag.
- resetn pulled low between the L and R beats:
  - all outputs are 0 in the same cycle; counters are 0; the next packet arbitrates cleanly from IDLE.
